// File: rtl/keyed_shift_engine.sv
// rtl/keyed_shift_engine.sv - keyed multi-round shift/rotate-and-add engine
module keyed_shift_engine #(
    parameter int WIDTH      = 16,
    parameter int KEY_W      = 5,
    parameter int MAX_ROUNDS = 8,
    parameter int ADD_CONST  = 3
) (
    input  logic                                  clk1,
    input  logic                                  rst,
    input  logic [KEY_W-1:0]                      key_bits,
    input  logic [WIDTH-1:0]                      input_data,
    input  logic                                  ld,
    input  logic                                  start,
    input  logic                                  rotate,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0]       n_rounds,
    output logic                                  busy,
    output logic                                  done,
    output logic [WIDTH-1:0]                      stg1_out
);

    localparam int NR_W = $clog2(MAX_ROUNDS + 1);
    localparam logic [WIDTH-1:0] ADD_C = WIDTH'(ADD_CONST);
    localparam logic [NR_W-1:0]  MAX_N = NR_W'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, READY, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   stg1_q, stg1_d;
    logic [NR_W-1:0]    cnt_q, cnt_d;
    logic [NR_W-1:0]    n_q, n_d;
    logic [2:0]         shamt_q, shamt_d;
    logic               rot_q, rot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NR_W-1:0]    n_eff;
    logic [NR_W-1:0]    cnt_inc;
    logic [2:0]         shamt_sel;
    logic               rot_sel;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   round_res;

    // Only the top three key bits steer the shift; the rest are don't-care.
    logic unused_key_ok;
    assign unused_key_ok = ^key_bits;

    // One round of the datapath; the start edge uses live inputs, later rounds the held copies.
    always_comb begin
        shamt_sel = (state_q == READY) ? key_bits[KEY_W-1 -: 3] : shamt_q;
        rot_sel   = (state_q == READY) ? rotate : rot_q;
        dbl       = {work_q, work_q} << shamt_sel;
        shifted   = rot_sel ? dbl[2*WIDTH-1:WIDTH] : (work_q << shamt_sel);
        round_res = shifted + ADD_C;
        cnt_inc   = cnt_q + NR_W'(1);
        if (n_rounds == '0) begin
            n_eff = NR_W'(1);
        end else if (n_rounds > MAX_N) begin
            n_eff = MAX_N;
        end else begin
            n_eff = n_rounds;
        end
    end

    // Next-state and next-output logic; ld overrides everything except reset.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        stg1_d  = stg1_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        shamt_d = shamt_q;
        rot_d   = rot_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (ld) begin
            work_d  = input_data;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = READY;
        end else begin
            case (state_q)
                READY: begin
                    if (start) begin
                        shamt_d = shamt_sel;
                        rot_d   = rot_sel;
                        n_d     = n_eff;
                        cnt_d   = NR_W'(1);
                        work_d  = round_res;
                        if (n_eff == NR_W'(1)) begin
                            stg1_d  = round_res;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    work_d = round_res;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == n_q) begin
                        stg1_d  = round_res;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; reset wins over ld and start.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            stg1_q  <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            shamt_q <= '0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            stg1_q  <= stg1_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            shamt_q <= shamt_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign stg1_out = stg1_q;

endmodule

// File: doc/keyed_shift_engine.md
KEYED_SHIFT_ENGINE -- requirements
Module: keyed_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data path width in bits, legal range 8..64.
REQ-002 SHALL have parameter KEY_W, default 5: key width in bits, minimum 3.
REQ-003 SHALL have parameter MAX_ROUNDS, default 8: maximum round count, minimum 1.
REQ-004 SHALL have parameter ADD_CONST, default 3: per-round additive constant, taken modulo 2^WIDTH.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL provide port clk1, input, 1 bit: sole clock; all logic acts on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL provide port key_bits, input, KEY_W bits: round key.
REQ-009 SHALL provide port input_data, input, WIDTH bits: data to load.
REQ-010 SHALL provide port ld, input, 1 bit: load strobe.
REQ-011 SHALL provide port start, input, 1 bit: start strobe.
REQ-012 SHALL provide port rotate, input, 1 bit: mode select, 0 = logical shift left, 1 = rotate left.
REQ-013 SHALL provide port n_rounds, input, clog2(MAX_ROUNDS+1) bits: requested round count.
REQ-014 SHALL provide port busy, output, 1 bit: high while rounds are in progress.
REQ-015 SHALL provide port done, output, 1 bit: result valid; level signal.
REQ-016 SHALL provide port stg1_out, output, WIDTH bits: result register.

Function
REQ-017 SHALL implement a state machine with states IDLE, READY, RUN and DONE.
REQ-018 SHALL, on ld in any state, capture input_data into the working register, clear done, drop busy and enter READY on the same edge; a run in progress is aborted with stg1_out unchanged.
REQ-019 SHALL give ld priority over start when both are high on the same edge.
REQ-020 SHALL ignore start in IDLE, RUN and DONE; only a new ld re-arms the block.
REQ-021 SHALL, on start in READY, sample key_bits, rotate and n_rounds and hold them for the whole run.
REQ-022 SHALL use a per-round shift amount equal to the top 3 key bits, key_bits[KEY_W-1:KEY_W-3], giving 0..7.
REQ-023 SHALL compute one round as: the working register shifted left (rotate=0) or rotated left (rotate=1) by the shift amount, plus ADD_CONST, truncated to WIDTH bits with the carry discarded.
REQ-024 SHALL treat an effective round count N of 0 as 1 and clamp any value above MAX_ROUNDS to MAX_ROUNDS.
REQ-025 SHALL execute round 1 on the start edge, then one round per clock; round k completes on edge start+(k-1).
REQ-026 SHALL, on the edge that completes round N, load the result into stg1_out, set done, clear busy and enter DONE; for N=1 this is the start edge itself.
REQ-027 SHALL hold busy high only while in RUN, which is entered only when N ≥ 2.
REQ-028 SHALL keep stg1_out stable except on a round-N completion edge or reset.
REQ-029 SHALL not change the loaded value on the working register during DONE; a new ld replaces it.

Reset
REQ-030 SHALL, on rst high at a clock edge, clear stg1_out, the working register and the round counter to 0, clear done and busy, and enter IDLE.
REQ-031 SHALL give rst priority over ld and start, and SHALL let reset during RUN discard the run without updating stg1_out.

Verification
REQ-032 SHALL be covered by a test with WIDTH=16, ld 0x0001, then start with key 5'b01100, rotate=0, n_rounds=1 -> same edge stg1_out=0x000B, done=1, busy never high.
REQ-033 SHALL be covered by a test with ld 0x8001, key 5'b00100, n_rounds=1, rotate=1 -> stg1_out=0x0006; the same test with rotate=0 -> stg1_out=0x0005.
REQ-034 SHALL be covered by a test with ld 0x0001, key 5'b01100, n_rounds=2 -> busy high for one cycle, then stg1_out=0x005B and done=1 one edge after start.
REQ-035 SHALL be covered by a test with ld 0xFFFF, key 0, n_rounds=0 -> one round, stg1_out=0x0002 (wrap); n_rounds=15 with MAX_ROUNDS=8 -> exactly 8 rounds.
REQ-036 SHALL be covered by a test with ld during RUN at round 3 of 8 -> busy=0, done=0, stg1_out unchanged, state READY; then start -> a full fresh run.
REQ-037 SHALL be covered by a test with rst during RUN, and with ld, start and rst on the same edge -> all outputs 0, IDLE; a later start without ld -> ignored.
